// File: rtl/md_hilo_ctrl_if.sv
// Execute-side bundle for the multiply/divide controller: request handshake,
// flush, mthi/mtlo write port and HI/LO read values.
interface md_hilo_ctrl_if;
  logic        md_req_valid;
  logic [3:0]  md_op;
  logic [31:0] md_src1;
  logic [31:0] md_src2;
  logic        md_req_ready;
  logic        md_cancel;
  logic        md_busy;
  logic        md_done;
  logic        mt_hi_we;
  logic        mt_lo_we;
  logic [31:0] mt_wdata;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;

  modport master (
    output md_req_valid, md_op, md_src1, md_src2, md_cancel,
           mt_hi_we, mt_lo_we, mt_wdata,
    input  md_req_ready, md_busy, md_done, hi_rdata, lo_rdata
  );

  modport slave (
    input  md_req_valid, md_op, md_src1, md_src2, md_cancel,
           mt_hi_we, mt_lo_we, mt_wdata,
    output md_req_ready, md_busy, md_done, hi_rdata, lo_rdata
  );
endinterface

// File: rtl/md_hilo_ctrl.sv
// HI/LO owner and mult/div sequencer: single-cycle multiply, 32-step
// restoring divide on magnitudes with sign fix-up at commit.
module md_hilo_ctrl #(
  parameter int DIV_ITER = 32
) (
  input  logic           clk,
  input  logic           resetn,
  md_hilo_ctrl_if.slave  md
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(DIV_ITER - 1);

  function automatic logic [31:0] abs32(input logic [31:0] val, input logic is_signed);
    logic [31:0] res;
    if (is_signed && val[31]) res = 32'd0 - val;
    else                      res = val;
    return res;
  endfunction

  state_t      state_r, state_s;
  logic        accept_s, done_s;
  logic        op_signed_r, q_neg_r, r_neg_r;
  logic [31:0] opa_r, opb_r, rem_r;
  logic [4:0]  cnt_r;
  logic [31:0] hi_r, lo_r;

  logic [32:0] rem_sh_s;
  logic [31:0] diff_s, rem_nx_s, quo_nx_s;
  logic        ge_s;
  logic [63:0] mul_a_s, mul_b_s, prod_s;
  logic [31:0] hi_res_s, lo_res_s;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= S_IDLE;
    else         state_r <= state_s;
  end

  // Next state, acceptance and done; cancel suppresses done
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        accept_s = md.md_req_valid & (|md.md_op) & ~md.md_cancel;
        if (accept_s) begin
          if (md.md_op[0] | md.md_op[1]) state_s = S_MUL;
          else                           state_s = S_DIV;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MUL: begin
        if (md.md_cancel) begin
          state_s = S_IDLE;
        end else begin
          done_s  = 1'b1;
          state_s = S_IDLE;
        end
      end
      S_DIV: begin
        if (md.md_cancel) begin
          state_s = S_IDLE;
        end else if (cnt_r == LAST_CNT) begin
          done_s  = 1'b1;
          state_s = S_IDLE;
        end else begin
          state_s = S_DIV;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // One shift-subtract step, the product, and the sign-fixed commit values
  always_comb begin
    rem_sh_s = {rem_r, opa_r[31]};
    ge_s     = (rem_sh_s >= {1'b0, opb_r});
    diff_s   = rem_sh_s[31:0] - opb_r;
    if (ge_s) rem_nx_s = diff_s;
    else      rem_nx_s = rem_sh_s[31:0];
    quo_nx_s = {opa_r[30:0], ge_s};
    mul_a_s  = {{32{op_signed_r & opa_r[31]}}, opa_r};
    mul_b_s  = {{32{op_signed_r & opb_r[31]}}, opb_r};
    prod_s   = mul_a_s * mul_b_s;
    if (state_r == S_MUL) begin
      hi_res_s = prod_s[63:32];
      lo_res_s = prod_s[31:0];
    end else begin
      if (r_neg_r) hi_res_s = 32'd0 - rem_nx_s;
      else         hi_res_s = rem_nx_s;
      if (q_neg_r) lo_res_s = 32'd0 - quo_nx_s;
      else         lo_res_s = quo_nx_s;
    end
  end

  // Operand latch at accept; dividend register shifts into the quotient while dividing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_signed_r <= 1'b0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      opa_r       <= 32'd0;
      opb_r       <= 32'd0;
      rem_r       <= 32'd0;
      cnt_r       <= 5'd0;
    end else if (accept_s) begin
      op_signed_r <= md.md_op[0] | md.md_op[2];
      q_neg_r     <= md.md_op[2] & (md.md_src1[31] ^ md.md_src2[31]);
      r_neg_r     <= md.md_op[2] & md.md_src1[31];
      opa_r       <= abs32(md.md_src1, md.md_op[2]);
      opb_r       <= abs32(md.md_src2, md.md_op[2]);
      rem_r       <= 32'd0;
      cnt_r       <= 5'd0;
    end else if (state_r == S_DIV) begin
      opa_r       <= quo_nx_s;
      rem_r       <= rem_nx_s;
      cnt_r       <= cnt_r + 5'd1;
    end
  end

  // HI/LO: op results at done, mthi/mtlo only while idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (done_s) begin
      hi_r <= hi_res_s;
      lo_r <= lo_res_s;
    end else if (state_r == S_IDLE) begin
      if (md.mt_hi_we) hi_r <= md.mt_wdata;
      if (md.mt_lo_we) lo_r <= md.mt_wdata;
    end
  end

  assign md.md_req_ready = (state_r == S_IDLE);
  assign md.md_busy      = (state_r == S_MUL) || (state_r == S_DIV);
  assign md.md_done      = done_s;
  assign md.hi_rdata     = hi_r;
  assign md.lo_rdata     = lo_r;

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed bench for md_hilo_ctrl: expected HI/LO pushed at issue, popped
// and compared after md_done; inputs driven and outputs sampled on negedge.
module tb_md_hilo_ctrl;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_DIVU  = 4'b1000;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   n_asserts = 0;
  int   n_fail = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_hilo_ctrl_if md_if ();

  md_hilo_ctrl #(.DIV_ITER(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (md_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hilo(input string tag);
    chk({tag, "_hi"}, {32'd0, md_if.hi_rdata}, {32'd0, m_hi});
    chk({tag, "_lo"}, {32'd0, md_if.lo_rdata}, {32'd0, m_lo});
  endtask

  task automatic mt_write(input logic hi_we, input logic lo_we, input logic [31:0] data);
    md_if.mt_hi_we = hi_we;
    md_if.mt_lo_we = lo_we;
    md_if.mt_wdata = data;
    @(negedge clk);
    md_if.mt_hi_we = 1'b0;
    md_if.mt_lo_we = 1'b0;
    if (hi_we) m_hi = data;
    if (lo_we) m_lo = data;
    chk_hilo("mt_write");
  endtask

  // Entered and left on a negedge; cancel_at/mt_at name a busy cycle (0 = unused)
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_hilo,
                        input int exp_cycles, input int cancel_at, input int mt_at);
    int   busy_cnt;
    logic hit;
    logic [63:0] e;
    busy_cnt = 0;
    hit = 1'b0;
    chk({tag, "_ready_at_issue"}, {63'd0, md_if.md_req_ready}, 64'd1);
    md_if.md_req_valid = 1'b1;
    md_if.md_op = op;
    md_if.md_src1 = a;
    md_if.md_src2 = b;
    if (cancel_at == 0) sb_q.push_back(exp_hilo);
    @(negedge clk);
    for (int g = 0; g < 100; g++) begin
      if (md_if.md_busy) busy_cnt++;
      if (mt_at != 0 && busy_cnt == mt_at) begin
        md_if.mt_hi_we = 1'b1;
        md_if.mt_wdata = 32'h55;
      end else begin
        md_if.mt_hi_we = 1'b0;
      end
      if (cancel_at != 0 && busy_cnt == cancel_at) begin
        md_if.md_cancel = 1'b1;
        #1;
        chk({tag, "_cancel_kills_done"}, {63'd0, md_if.md_done}, 64'd0);
        hit = 1'b1;
        break;
      end
      if (md_if.md_done) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_finished_in_budget"}, {63'd0, hit}, 64'd1);
    if (cancel_at == 0)
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_cycles));
    @(negedge clk);
    md_if.md_req_valid = 1'b0;
    md_if.md_cancel = 1'b0;
    md_if.mt_hi_we = 1'b0;
    md_if.md_op = 4'd0;
    chk({tag, "_ready_after"}, {63'd0, md_if.md_req_ready}, 64'd1);
    chk({tag, "_busy_after"}, {63'd0, md_if.md_busy}, 64'd0);
    if (cancel_at == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(sb_q.size()), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        m_hi = e[63:32];
        m_lo = e[31:0];
      end
    end
    chk_hilo(tag);
  endtask

  initial begin
    md_if.md_req_valid = 1'b0;
    md_if.md_op = 4'd0;
    md_if.md_src1 = 32'd0;
    md_if.md_src2 = 32'd0;
    md_if.md_cancel = 1'b0;
    md_if.mt_hi_we = 1'b0;
    md_if.mt_lo_we = 1'b0;
    md_if.mt_wdata = 32'd0;

    #2 resetn = 1'b0;
    #1;
    chk("rst_ready", {63'd0, md_if.md_req_ready}, 64'd1);
    chk("rst_busy", {63'd0, md_if.md_busy}, 64'd0);
    chk("rst_done", {63'd0, md_if.md_done}, 64'd0);
    chk_hilo("rst");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1, 0, 0);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1, 0, 0);
    run_op("mult_mixed", OP_MULT, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1, 0, 0);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 32, 0, 0);
    run_op("divu_zero", OP_DIVU, 32'd10, 32'd0, 64'h0000000A_FFFFFFFF, 32, 0, 0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 32, 0, 0);
    run_op("div_negdiv", OP_DIV, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 32, 0, 0);

    // valid with no op bit set must be ignored
    md_if.md_req_valid = 1'b1;
    md_if.md_op = 4'd0;
    @(negedge clk);
    chk("op0_busy", {63'd0, md_if.md_busy}, 64'd0);
    chk("op0_ready", {63'd0, md_if.md_req_ready}, 64'd1);
    md_if.md_req_valid = 1'b0;

    // cancel in idle blocks acceptance
    md_if.md_req_valid = 1'b1;
    md_if.md_op = OP_MULT;
    md_if.md_cancel = 1'b1;
    @(negedge clk);
    chk("idle_cancel_busy", {63'd0, md_if.md_busy}, 64'd0);
    md_if.md_req_valid = 1'b0;
    md_if.md_cancel = 1'b0;
    md_if.md_op = 4'd0;

    mt_write(1'b1, 1'b0, 32'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    run_op("divu_cancel", OP_DIVU, 32'd100, 32'd3, 64'd0, 0, 10, 0);
    run_op("mult_cancel", OP_MULT, 32'd6, 32'd7, 64'd0, 0, 1, 0);
    mt_write(1'b1, 1'b1, 32'h33);
    run_op("divu_mt_busy", OP_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 32, 0, 5);

    // async reset in the middle of a divide
    md_if.md_req_valid = 1'b1;
    md_if.md_op = OP_DIVU;
    md_if.md_src1 = 32'd1000;
    md_if.md_src2 = 32'd9;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", {63'd0, md_if.md_busy}, 64'd1);
    #2 resetn = 1'b0;
    #1;
    md_if.md_req_valid = 1'b0;
    md_if.md_op = 4'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("midrst_busy", {63'd0, md_if.md_busy}, 64'd0);
    chk("midrst_done", {63'd0, md_if.md_done}, 64'd0);
    chk_hilo("midrst");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("postrst_ready", {63'd0, md_if.md_req_ready}, 64'd1);
    chk_hilo("postrst");
    run_op("mult_after_rst", OP_MULTU, 32'd6, 32'd7, 64'h00000000_0000002A, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/md_hilo_ctrl.md
Name: md_hilo_ctrl

Overview:
- Multiply/divide sequencer and HI/LO register owner for the 5-stage MIPS core.
- Sits beside the execute stage and accepts mult/multu/div/divu requests from it.
- Runs a single-cycle multiply and a 32-iteration restoring divider, then commits results to HI/LO.
- Provides the stall/done signals execute needs, plus HI/LO read values and mthi/mtlo write ports.

Parameters:
- DIV_ITER, 32, number of divider iterations; fixed at the operand width, must not be changed.

Ports:
- clk  input  1  clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- md_req_valid  input  1  execute presents an md op this cycle
- md_op  input  4  one-hot: [0] mult, [1] multu, [2] div, [3] divu
- md_src1  input  32  rs value (multiplicand / dividend)
- md_src2  input  32  rt value (multiplier / divisor)
- md_req_ready  output  1  controller can accept a request (state IDLE)
- md_cancel  input  1  flush: abort any in-flight op
- md_busy  output  1  op in flight (state MUL or DIV)
- md_done  output  1  high in the last busy cycle; HI/LO written at that cycle's closing edge
- mt_hi_we  input  1  mthi write enable
- mt_lo_we  input  1  mtlo write enable
- mt_wdata  input  32  mthi/mtlo data
- hi_rdata  output  32  current HI register
- lo_rdata  output  32  current LO register

Behaviour:
- Reset (resetn=0, async, also mid-operation):
  - state IDLE; HI=LO=0; counter=0; operand/partial registers 0.
  - md_busy=0, md_done=0, md_req_ready=1.
- States: IDLE, MUL, DIV.
- Accept: md_req_valid & md_req_ready & |md_op & ~md_cancel.
  - Operands and op are latched at the accepting edge.
  - md_req_valid with md_op==0 is ignored; no state change.
  - md_op with more than one bit set is illegal; the bench must not drive it.
- IDLE→MUL on accepted mult/multu.
  - One MUL cycle with md_done=1.
  - 64-bit product from latched operands (signed for mult, zero-extended for multu).
  - Closing edge writes HI=product[63:32], LO=product[31:0]; state→IDLE.
- IDLE→DIV on accepted div/divu.
  - At accept: latch |src1| and |src2| (signed), or raw values (unsigned); record sign of dividend and sign of quotient (src1[31]^src2[31]); clear remainder; counter=0.
  - Each DIV cycle does one shift-subtract step: remainder = {remainder[31:0], dividend MSB}; if it is ≥ divisor, subtract and shift in quotient bit 1, else 0.
  - counter increments each DIV cycle; md_done=1 when counter==DIV_ITER-1, so there are exactly 32 busy cycles.
  - Closing edge of the done cycle: LO=quotient, negated if the quotient sign is set; HI=remainder, negated if the dividend was negative. State→IDLE.
- Execute-stage contract: es_ready_go = ~is_md_op | md_done.
  - The request stays asserted while busy; md_req_ready=0 prevents re-acceptance.
  - A new request can be accepted in the cycle after md_done.
- Divide by zero:
  - divu: LO=0xFFFFFFFF, HI=src1.
  - div: result is whatever the algorithm plus sign fix produces; architecturally unpredictable, not checked.
- Signed overflow: 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
- md_cancel:
  - In MUL/DIV: next edge state→IDLE, no HI/LO write. md_done is forced to 0 in that cycle, so cancel wins over a simultaneous done.
  - In IDLE: blocks acceptance.
  - Does not block mt writes.
- mthi/mtlo:
  - Take effect at the edge only in IDLE; ignored while busy (the pipeline stalls them on md_busy).
  - Both enables together write HI and LO.
  - An mt write in the same IDLE cycle as an accept still commits; the op's result overwrites it later.
- hi_rdata/lo_rdata are the register outputs; no same-cycle bypass, so a write is visible the next cycle.

Test Plan:
- Mult, signed: mult src1=0xFFFFFFFD (-3), src2=7 → md_done exactly 1 cycle after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB; md_req_ready back to 1 the following cycle.
- Mult, unsigned: multu 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Div, signed: div -7 (0xFFFFFFF9) / 2 → md_busy high 32 cycles, md_done in the 32nd only; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divu by zero and signed overflow: divu 10/0 → LO=0xFFFFFFFF, HI=0x0000000A. Then div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Cancel mid-div: preload HI=0x11, LO=0x22 via mt ports; start divu 100/3; pulse md_cancel on busy cycle 10 → no md_done, HI/LO stay 0x11/0x22, md_req_ready=1 next cycle.
- Mt while busy and async reset: mthi 0x55 during a div is ignored (HI = remainder afterwards). Drop resetn mid-div → outputs clear immediately; HI=LO=0, md_req_ready=1 after release.
